serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_fa.sv | 13 +
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM encoding, default width and counter sizing for serial_add_ctrl
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// rtl/serial_add_ctrl_fa.sv - single-bit full adder reused once per cycle by serial_add_ctrl
module fa (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial LSB-first adder with IDLE/SHIFT/DONE control
// Optional two's-complement overflow output ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_next = {fa_sum, res_sr[WIDTH-1:1]};

  fa u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  // The counter holds on the final bit so it never wraps when WIDTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_next;
          carry  <= fa_cout;
          if (last_bit) begin
            sum  <= res_next;
            cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf  <= carry ^ fa_cout;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl against an arithmetic reference model
module tb_serial_add_ctrl;

  localparam int W = 8;
  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                output logic [W-1:0] s, output logic co, output logic ov);
    int unsigned u;
    int sg;
    u  = int'(x) + int'(y) + int'(ci);
    s  = u[W-1:0];
    co = u[W];
    sg = int'($signed(x)) + int'($signed(y)) + int'(ci);
    ov = (sg > (2 ** (W - 1)) - 1) || (sg < -(2 ** (W - 1)));
  endfunction

  // Starts an operation from a negedge; returns negedges counted until done (W+1 expected).
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input bit scramble, input int repulse_at, output int lat);
    a = x; b = y; cin = ci; start = 1'b1;
    lat = 0;
    while (lat < TMO) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (repulse_at > 0 && lat == repulse_at) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end
      if (repulse_at > 0 && lat == repulse_at + 1) start = 1'b0;
      if (done) break;
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        start = 1'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input bit scramble);
    logic [W-1:0] es;
    logic eco, eov;
    int lat;
    model(x, y, ci, es, eco, eov);
    run_op(x, y, ci, scramble, 0, lat);
    total++;
    if (lat !== W + 1) begin
      bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, W + 1);
    end
    total++;
    if (sum !== es || cout !== eco) begin
      bad++; $display("FAIL %s result got sum=%h cout=%b exp sum=%h cout=%b", name, sum, cout, es, eco);
    end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if (ovf !== eov) begin
      bad++; $display("FAIL %s ovf got=%b exp=%b", name, ovf, eov);
    end
`endif
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after_done got done=%b busy=%b exp done=0 busy=0", name, done, busy);
    end
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    @(negedge clk);
    total++;
    if (sum !== es || cout !== eco) begin
      bad++; $display("FAIL %s hold got sum=%h cout=%b exp sum=%h cout=%b", name, sum, cout, es, eco);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      bad++; $display("FAIL reset got busy=%b done=%b sum=%h cout=%b exp 0 0 00 0", busy, done, sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL reset_ovf got=%b exp=0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_op("basic", 8'h5A, 8'h33, 1'b0, 1'b0);
    check_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    check_op("carry_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    check_op("signed_ovf", 8'h80, 8'h80, 1'b0, 1'b0);
  endtask

  task automatic test_busy_protect();
    int lat;
    int extra;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 3, lat);
    total++;
    if (lat !== W + 1 || sum !== 8'h03 || cout !== 1'b0) begin
      bad++; $display("FAIL busy_protect got lat=%0d sum=%h cout=%b exp lat=%0d sum=03 cout=0", lat, sum, cout, W + 1);
    end
    extra = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL busy_protect_second_done got=%0d exp=0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int dones;
    a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      bad++; $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b exp 0 0 00 0", busy, done, sum, cout);
    end
    rst_n = 1'b1;
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL reset_mid_no_done got=%0d exp=0", dones);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 0, lat);
    total++;
    if (lat !== W + 1 || sum !== 8'h30 || cout !== 1'b0) begin
      bad++; $display("FAIL reset_mid_restart got lat=%0d sum=%h cout=%b exp lat=%0d sum=30 cout=0", lat, sum, cout, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      check_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] es;
    logic eco, eov;
    int prev;
    int n;
    a = 8'h3C; b = 8'hA7; cin = 1'b1;
    model(a, b, cin, es, eco, eov);
    start = 1'b1;
    prev = -1;
    n = 0;
    for (int cyc = 1; cyc <= 3 * (W + 2) + 5; cyc++) begin
      @(negedge clk);
      if (done) begin
        total++;
        if (sum !== es || cout !== eco) begin
          bad++; $display("FAIL back_to_back result got sum=%h cout=%b exp sum=%h cout=%b", sum, cout, es, eco);
        end
        if (prev >= 0) begin
          total++;
          if (cyc - prev !== W + 2) begin
            bad++; $display("FAIL back_to_back spacing got=%0d exp=%0d", cyc - prev, W + 2);
          end
        end
        prev = cyc;
        n++;
      end
    end
    start = 1'b0;
    total++;
    if (n !== 3) begin
      bad++; $display("FAIL back_to_back count got=%0d exp=3", n);
    end
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_protect();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
